// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode field widths, opcode
// encodings for {log,hc,sc}, and the in-flight record layout.
package alu_arbiter_pkg;

   localparam int unsigned LOG_W = 1;
   localparam int unsigned HC_W  = 2;
   localparam int unsigned SC_W  = 3;
   localparam int unsigned OP_W  = LOG_W + HC_W + SC_W;

   // {log, hc, sc} encodings
   localparam logic [OP_W-1:0] OP_ADD  = 6'b000_000;
   localparam logic [OP_W-1:0] OP_SUB  = 6'b000_001;
   localparam logic [OP_W-1:0] OP_ADDC = 6'b000_010;
   localparam logic [OP_W-1:0] OP_SUBB = 6'b000_011;
   localparam logic [OP_W-1:0] OP_COMP = 6'b000_101;

   // Op tracked through the ALU result cycle
   typedef struct packed {
      logic valid;
      logic id;
      logic sat;
      logic ci;
   } inflight_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-input grant logic for the ALU arbiter.
// Ports: clk_exe/reset (async, active-low), stall, req0/req1 requests,
// grant0_c/grant1_c combinational one-hot grants. last_grant records the
// most recent winner and steers round-robin ties.
module alu_rr_pick
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic clk_exe,
   input  logic reset,
   input  logic stall,
   input  logic req0,
   input  logic req1,
   output logic grant0_c,
   output logic grant1_c
);

   logic last_grant;
   logic allow;

   // No grants during reset so every output reads zero while it is asserted
   assign allow = reset & ~stall;

   // Grant selection
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (allow) begin
         if (req0 && req1) begin
            if ((ROUND_ROBIN != 0) && (last_grant == 1'b0)) grant1_c = 1'b1;
            else                                           grant0_c = 1'b1;
         end else begin
            grant0_c = req0;
            grant1_c = req1;
         end
      end
   end

   // Winner of the latest transfer; resets to 1 so r0 takes the first tie
   always_ff @(posedge clk_exe or negedge reset) begin
      if (!reset)                    last_grant <= 1'b1;
      else if (grant0_c || grant1_c) last_grant <= grant1_c;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared ALU.
// Ports: clk_exe, reset (async, active-low), stall; requester N request
// (rN_valid/rN_ready, opcode fields, operands); ALU issue bus (ps_alu_*,
// xb_dtx/xb_dty); ALU result-cycle controls (ps_alu_sat/ps_alu_ci); ALU
// result and flags in; registered response (rsp_*); per-requester sticky
// overflow with clear.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic                  clk_exe,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  r0_valid,
   output logic                  r0_ready,
   input  logic                  r0_log,
   input  logic [HC_W-1:0]       r0_hc,
   input  logic [SC_W-1:0]       r0_sc,
   input  logic                  r0_sat,
   input  logic                  r0_ci,
   input  logic [DATA_WIDTH-1:0] r0_x,
   input  logic [DATA_WIDTH-1:0] r0_y,
   input  logic                  r1_valid,
   output logic                  r1_ready,
   input  logic                  r1_log,
   input  logic [HC_W-1:0]       r1_hc,
   input  logic [SC_W-1:0]       r1_sc,
   input  logic                  r1_sat,
   input  logic                  r1_ci,
   input  logic [DATA_WIDTH-1:0] r1_x,
   input  logic [DATA_WIDTH-1:0] r1_y,
   output logic                  ps_alu_en,
   output logic                  ps_alu_log,
   output logic [HC_W-1:0]       ps_alu_hc,
   output logic [SC_W-1:0]       ps_alu_sc,
   output logic [DATA_WIDTH-1:0] xb_dtx,
   output logic [DATA_WIDTH-1:0] xb_dty,
   output logic                  ps_alu_sat,
   output logic                  ps_alu_ci,
   input  logic [DATA_WIDTH-1:0] alu_xb_dt,
   input  logic                  alu_ps_az,
   input  logic                  alu_ps_an,
   input  logic                  alu_ps_ac,
   input  logic                  alu_ps_av,
   input  logic                  alu_ps_compd,
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_dt,
   output logic                  rsp_az,
   output logic                  rsp_an,
   output logic                  rsp_ac,
   output logic                  rsp_av,
   output logic                  rsp_compd,
   output logic [1:0]            sticky_av,
   input  logic [1:0]            sticky_clr
);

   logic      grant0_c;
   logic      grant1_c;
   logic      xfer_c;
   logic      issue_sat_c;
   logic      issue_ci_c;
   logic      sat_hold;
   logic [1:0] av_set_c;
   inflight_t inflight_q;

   alu_rr_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
      .clk_exe  (clk_exe),
      .reset    (reset),
      .stall    (stall),
      .req0     (r0_valid),
      .req1     (r1_valid),
      .grant0_c (grant0_c),
      .grant1_c (grant1_c)
   );

   assign r0_ready  = grant0_c;
   assign r1_ready  = grant1_c;
   assign xfer_c    = grant0_c | grant1_c;
   assign ps_alu_en = xfer_c;

   // Issue mux; all zeros when nothing transfers
   always_comb begin
      ps_alu_log  = 1'b0;
      ps_alu_hc   = '0;
      ps_alu_sc   = '0;
      xb_dtx      = '0;
      xb_dty      = '0;
      issue_sat_c = 1'b0;
      issue_ci_c  = 1'b0;
      if (grant0_c) begin
         ps_alu_log  = r0_log;
         ps_alu_hc   = r0_hc;
         ps_alu_sc   = r0_sc;
         xb_dtx      = r0_x;
         xb_dty      = r0_y;
         issue_sat_c = r0_sat;
         issue_ci_c  = r0_ci;
      end else if (grant1_c) begin
         ps_alu_log  = r1_log;
         ps_alu_hc   = r1_hc;
         ps_alu_sc   = r1_sc;
         xb_dtx      = r1_x;
         xb_dty      = r1_y;
         issue_sat_c = r1_sat;
         issue_ci_c  = r1_ci;
      end
   end

   // In-flight register: one entry per transfer, cleared on idle cycles
   always_ff @(posedge clk_exe or negedge reset) begin
      if (!reset)      inflight_q <= '0;
      else if (xfer_c) inflight_q <= {1'b1, grant1_c, issue_sat_c, issue_ci_c};
      else             inflight_q <= '0;
   end

   // Result-cycle controls come from the in-flight op; sat holds when idle
   always_ff @(posedge clk_exe or negedge reset) begin
      if (!reset)                sat_hold <= 1'b0;
      else if (inflight_q.valid) sat_hold <= inflight_q.sat;
   end

   assign ps_alu_sat = inflight_q.valid ? inflight_q.sat : sat_hold;
   assign ps_alu_ci  = inflight_q.valid & inflight_q.ci;

   // Response register: strobe each in-flight op, hold data until the next
   always_ff @(posedge clk_exe or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_dt    <= '0;
         rsp_az    <= 1'b0;
         rsp_an    <= 1'b0;
         rsp_ac    <= 1'b0;
         rsp_av    <= 1'b0;
         rsp_compd <= 1'b0;
      end else begin
         rsp_valid <= inflight_q.valid;
         if (inflight_q.valid) begin
            rsp_id    <= inflight_q.id;
            rsp_dt    <= alu_xb_dt;
            rsp_az    <= alu_ps_az;
            rsp_an    <= alu_ps_an;
            rsp_ac    <= alu_ps_ac;
            rsp_av    <= alu_ps_av;
            rsp_compd <= alu_ps_compd;
         end
      end
   end

   // Sticky overflow; a coincident set overrides the clear
   always_comb begin
      av_set_c = 2'b00;
      if (inflight_q.valid && alu_ps_av) av_set_c = inflight_q.id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk_exe or negedge reset) begin
      if (!reset) sticky_av <= 2'b00;
      else        sticky_av <= (sticky_av & ~sticky_clr) | av_set_c;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU. A second
// instance with fixed priority shares all inputs for the priority checks.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk_exe = 1'b0;
   logic        reset;
   logic        stall;
   logic        r0_valid, r0_log, r0_sat, r0_ci;
   logic [1:0]  r0_hc;
   logic [2:0]  r0_sc;
   logic [15:0] r0_x, r0_y;
   logic        r1_valid, r1_log, r1_sat, r1_ci;
   logic [1:0]  r1_hc;
   logic [2:0]  r1_sc;
   logic [15:0] r1_x, r1_y;
   logic [1:0]  sticky_clr;
   logic [15:0] alu_xb_dt;
   logic        alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd;

   logic        r0_ready, r1_ready, ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_ci;
   logic [1:0]  ps_alu_hc;
   logic [2:0]  ps_alu_sc;
   logic [15:0] xb_dtx, xb_dty, rsp_dt;
   logic        rsp_valid, rsp_id, rsp_az, rsp_an, rsp_ac, rsp_av, rsp_compd;
   logic [1:0]  sticky_av;

   logic        fp_r0_ready, fp_r1_ready, fp_en, fp_log, fp_sat, fp_ci;
   logic [1:0]  fp_hc;
   logic [2:0]  fp_sc;
   logic [15:0] fp_dtx, fp_dty, fp_rsp_dt;
   logic        fp_rsp_valid, fp_rsp_id, fp_az, fp_an, fp_ac, fp_av, fp_compd;
   logic [1:0]  fp_sticky;

   int checks = 0;
   int errors = 0;

   always #5 clk_exe = ~clk_exe;

   alu_arbiter #(.DATA_WIDTH(16), .ROUND_ROBIN(1)) dut (
      .clk_exe(clk_exe), .reset(reset), .stall(stall),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_log(r0_log), .r0_hc(r0_hc),
      .r0_sc(r0_sc), .r0_sat(r0_sat), .r0_ci(r0_ci), .r0_x(r0_x), .r0_y(r0_y),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_log(r1_log), .r1_hc(r1_hc),
      .r1_sc(r1_sc), .r1_sat(r1_sat), .r1_ci(r1_ci), .r1_x(r1_x), .r1_y(r1_y),
      .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_hc(ps_alu_hc),
      .ps_alu_sc(ps_alu_sc), .xb_dtx(xb_dtx), .xb_dty(xb_dty),
      .ps_alu_sat(ps_alu_sat), .ps_alu_ci(ps_alu_ci), .alu_xb_dt(alu_xb_dt),
      .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac),
      .alu_ps_av(alu_ps_av), .alu_ps_compd(alu_ps_compd),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dt(rsp_dt), .rsp_az(rsp_az),
      .rsp_an(rsp_an), .rsp_ac(rsp_ac), .rsp_av(rsp_av), .rsp_compd(rsp_compd),
      .sticky_av(sticky_av), .sticky_clr(sticky_clr)
   );

   alu_arbiter #(.DATA_WIDTH(16), .ROUND_ROBIN(0)) dut_fp (
      .clk_exe(clk_exe), .reset(reset), .stall(stall),
      .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_log(r0_log), .r0_hc(r0_hc),
      .r0_sc(r0_sc), .r0_sat(r0_sat), .r0_ci(r0_ci), .r0_x(r0_x), .r0_y(r0_y),
      .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_log(r1_log), .r1_hc(r1_hc),
      .r1_sc(r1_sc), .r1_sat(r1_sat), .r1_ci(r1_ci), .r1_x(r1_x), .r1_y(r1_y),
      .ps_alu_en(fp_en), .ps_alu_log(fp_log), .ps_alu_hc(fp_hc),
      .ps_alu_sc(fp_sc), .xb_dtx(fp_dtx), .xb_dty(fp_dty),
      .ps_alu_sat(fp_sat), .ps_alu_ci(fp_ci), .alu_xb_dt(alu_xb_dt),
      .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac),
      .alu_ps_av(alu_ps_av), .alu_ps_compd(alu_ps_compd),
      .rsp_valid(fp_rsp_valid), .rsp_id(fp_rsp_id), .rsp_dt(fp_rsp_dt), .rsp_az(fp_az),
      .rsp_an(fp_an), .rsp_ac(fp_ac), .rsp_av(fp_av), .rsp_compd(fp_compd),
      .sticky_av(fp_sticky), .sticky_clr(sticky_clr)
   );

   // Behavioural ALU: latches the issued op, computes during its result cycle
   logic        alu_v;
   logic [5:0]  alu_op;
   logic [15:0] alu_x, alu_y, res;
   logic [16:0] sum17;
   logic        ovf;

   always @(posedge clk_exe) begin
      alu_v  <= ps_alu_en;
      alu_op <= {ps_alu_log, ps_alu_hc, ps_alu_sc};
      alu_x  <= xb_dtx;
      alu_y  <= xb_dty;
   end

   always_comb begin
      res = 16'h0000; sum17 = 17'h0; ovf = 1'b0;
      alu_ps_ac = 1'b0; alu_ps_compd = 1'b0;
      if (alu_v) begin
         if (alu_op == OP_ADD || alu_op == OP_ADDC) begin
            sum17 = {1'b0, alu_x} + {1'b0, alu_y} + {16'h0, (alu_op == OP_ADDC) & ps_alu_ci};
            res = sum17[15:0];
            ovf = (alu_x[15] == alu_y[15]) && (res[15] != alu_x[15]);
            alu_ps_ac = sum17[16];
            if (ovf && ps_alu_sat) res = alu_x[15] ? 16'h8000 : 16'h7fff;
         end else begin
            res = alu_x - alu_y - {15'h0, (alu_op == OP_SUBB) & ~ps_alu_ci};
            ovf = (alu_x[15] != alu_y[15]) && (res[15] != alu_x[15]);
            alu_ps_compd = (alu_op == OP_COMP);
         end
      end
      alu_xb_dt = res;
      alu_ps_av = ovf;
      alu_ps_az = alu_v && (res == 16'h0000);
      alu_ps_an = res[15];
   end

   task automatic tick();
      @(posedge clk_exe); #1;
   endtask

   task automatic drive0(input logic v, input logic [5:0] op, input logic sat, input logic ci,
                         input logic [15:0] x, input logic [15:0] y);
      r0_valid = v; {r0_log, r0_hc, r0_sc} = op; r0_sat = sat; r0_ci = ci; r0_x = x; r0_y = y;
   endtask

   task automatic drive1(input logic v, input logic [5:0] op, input logic sat, input logic ci,
                         input logic [15:0] x, input logic [15:0] y);
      r1_valid = v; {r1_log, r1_hc, r1_sc} = op; r1_sat = sat; r1_ci = ci; r1_x = x; r1_y = y;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; sticky_clr = 2'b00;
      drive0(1'b1, OP_ADD, 1'b1, 1'b1, 16'h1111, 16'h2222);
      drive1(1'b0, OP_ADD, 1'b0, 1'b0, 16'h0, 16'h0);
      tick(); tick();
      checks++; if (r0_ready !== 1'b0 || ps_alu_en !== 1'b0) begin errors++;
         $display("FAIL reset_grant ready=%b en=%b expected 0 0", r0_ready, ps_alu_en); end
      checks++; if (rsp_valid !== 1'b0 || sticky_av !== 2'b00 || ps_alu_sat !== 1'b0 || rsp_dt !== 16'h0) begin errors++;
         $display("FAIL reset_state rsp_valid=%b sticky=%b sat=%b dt=%h expected zeros", rsp_valid, sticky_av, ps_alu_sat, rsp_dt); end
      checks++; if (xb_dtx !== 16'h0 || ps_alu_ci !== 1'b0) begin errors++;
         $display("FAIL reset_bus dtx=%h ci=%b expected 0", xb_dtx, ps_alu_ci); end
      r0_valid = 1'b0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_add();
      drive0(1'b1, OP_ADD, 1'b0, 1'b0, 16'h0003, 16'h0004);
      #1;
      checks++; if (r0_ready !== 1'b1 || ps_alu_en !== 1'b1 || xb_dtx !== 16'h0003 || xb_dty !== 16'h0004) begin errors++;
         $display("FAIL add_issue ready=%b en=%b x=%h y=%h expected 1 1 0003 0004", r0_ready, ps_alu_en, xb_dtx, xb_dty); end
      tick(); r0_valid = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0 || ps_alu_en !== 1'b0) begin errors++;
         $display("FAIL add_c1 rsp_valid=%b en=%b expected 0 0", rsp_valid, ps_alu_en); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_dt !== 16'h0007) begin errors++;
         $display("FAIL add_rsp valid=%b id=%b dt=%h expected 1 0 0007", rsp_valid, rsp_id, rsp_dt); end
      checks++; if ({rsp_az, rsp_an, rsp_ac, rsp_av, rsp_compd} !== 5'b00000) begin errors++;
         $display("FAIL add_flags got %b expected 00000", {rsp_az, rsp_an, rsp_ac, rsp_av, rsp_compd}); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || rsp_dt !== 16'h0007) begin errors++;
         $display("FAIL add_hold valid=%b dt=%h expected 0 0007", rsp_valid, rsp_dt); end
   endtask

   task automatic test_saturate();
      drive1(1'b1, OP_ADD, 1'b1, 1'b0, 16'h7fff, 16'h0001);
      #1;
      checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin errors++;
         $display("FAIL sat_issue r1_ready=%b r0_ready=%b expected 1 0", r1_ready, r0_ready); end
      tick(); r1_valid = 1'b0; #1;
      checks++; if (ps_alu_sat !== 1'b1) begin errors++;
         $display("FAIL sat_c1_ctrl ps_alu_sat=%b expected 1", ps_alu_sat); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_dt !== 16'h7fff || rsp_av !== 1'b1) begin errors++;
         $display("FAIL sat_rsp valid=%b id=%b dt=%h av=%b expected 1 1 7fff 1", rsp_valid, rsp_id, rsp_dt, rsp_av); end
      checks++; if (sticky_av !== 2'b10 || ps_alu_sat !== 1'b1) begin errors++;
         $display("FAIL sat_sticky sticky=%b hold_sat=%b expected 10 1", sticky_av, ps_alu_sat); end
      sticky_clr = 2'b10;
      tick(); sticky_clr = 2'b00; #1;
      checks++; if (sticky_av !== 2'b00) begin errors++;
         $display("FAIL sat_clear sticky=%b expected 00", sticky_av); end
   endtask

   task automatic test_round_robin();
      drive0(1'b1, OP_ADD, 1'b0, 1'b0, 16'h0010, 16'h0001);
      drive1(1'b1, OP_ADD, 1'b0, 1'b0, 16'h0020, 16'h0002);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (r0_ready !== ((i % 2) == 0) || r1_ready !== ((i % 2) == 1)) begin errors++;
            $display("FAIL rr_tie_%0d r0=%b r1=%b expected %b %b", i, r0_ready, r1_ready, (i % 2) == 0, (i % 2) == 1); end
         checks++; if (fp_r0_ready !== 1'b1 || fp_r1_ready !== 1'b0) begin errors++;
            $display("FAIL fp_tie_%0d r0=%b r1=%b expected 1 0", i, fp_r0_ready, fp_r1_ready); end
         tick();
      end
      r0_valid = 1'b0; #1;
      checks++; if (fp_r1_ready !== 1'b1) begin errors++;
         $display("FAIL fp_r1_alone r1_ready=%b expected 1", fp_r1_ready); end
      tick(); r1_valid = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_back_to_back();
      drive0(1'b1, OP_ADDC, 1'b0, 1'b1, 16'h0001, 16'h0001);
      #1;
      checks++; if (r0_ready !== 1'b1) begin errors++;
         $display("FAIL b2b_issue0 ready=%b expected 1", r0_ready); end
      tick();
      drive0(1'b1, OP_COMP, 1'b0, 1'b0, 16'h0005, 16'h0005);
      #1;
      checks++; if (ps_alu_en !== 1'b1 || ps_alu_ci !== 1'b1 || {ps_alu_log, ps_alu_hc, ps_alu_sc} !== OP_COMP) begin errors++;
         $display("FAIL b2b_overlap en=%b ci=%b op=%b expected 1 1 000101", ps_alu_en, ps_alu_ci, {ps_alu_log, ps_alu_hc, ps_alu_sc}); end
      tick(); r0_valid = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_dt !== 16'h0003 || ps_alu_ci !== 1'b0) begin errors++;
         $display("FAIL b2b_rsp0 valid=%b dt=%h ci=%b expected 1 0003 0", rsp_valid, rsp_dt, ps_alu_ci); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_dt !== 16'h0000 || rsp_az !== 1'b1 || rsp_compd !== 1'b1) begin errors++;
         $display("FAIL b2b_rsp1 valid=%b dt=%h az=%b compd=%b expected 1 0000 1 1", rsp_valid, rsp_dt, rsp_az, rsp_compd); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_end rsp_valid=%b expected 0", rsp_valid); end
   endtask

   task automatic test_stall();
      drive0(1'b1, OP_ADD, 1'b0, 1'b0, 16'h0002, 16'h0003);
      #1;
      checks++; if (r0_ready !== 1'b1) begin errors++;
         $display("FAIL stall_pre ready=%b expected 1", r0_ready); end
      tick();
      drive0(1'b1, OP_ADD, 1'b0, 1'b0, 16'h0001, 16'h0001);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (r0_ready !== 1'b0 || ps_alu_en !== 1'b0) begin errors++;
            $display("FAIL stall_%0d ready=%b en=%b expected 0 0", i, r0_ready, ps_alu_en); end
         if (i == 1) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_dt !== 16'h0005) begin errors++;
               $display("FAIL stall_rsp valid=%b dt=%h expected 1 0005", rsp_valid, rsp_dt); end
         end
         tick();
      end
      stall = 1'b0; #1;
      checks++; if (r0_ready !== 1'b1) begin errors++;
         $display("FAIL stall_release ready=%b expected 1", r0_ready); end
      tick(); r0_valid = 1'b0;
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_dt !== 16'h0002) begin errors++;
         $display("FAIL stall_post_rsp valid=%b dt=%h expected 1 0002", rsp_valid, rsp_dt); end
      tick();
   endtask

   task automatic test_reset_mid_op();
      drive0(1'b1, OP_ADD, 1'b1, 1'b0, 16'h7fff, 16'h0001);
      tick(); r0_valid = 1'b0;
      tick();
      checks++; if (sticky_av !== 2'b01) begin errors++;
         $display("FAIL mid_sticky_set sticky=%b expected 01", sticky_av); end
      drive0(1'b1, OP_ADD, 1'b1, 1'b0, 16'h0001, 16'h0001);
      tick(); r0_valid = 1'b0; #1;
      checks++; if (ps_alu_sat !== 1'b1) begin errors++;
         $display("FAIL mid_c1_sat ps_alu_sat=%b expected 1", ps_alu_sat); end
      #2 reset = 1'b0;
      r0_valid = 1'b1; r1_valid = 1'b1; #1;
      checks++; if (sticky_av !== 2'b00 || rsp_valid !== 1'b0 || ps_alu_sat !== 1'b0) begin errors++;
         $display("FAIL mid_reset_regs sticky=%b rsp_valid=%b sat=%b expected 00 0 0", sticky_av, rsp_valid, ps_alu_sat); end
      checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || ps_alu_en !== 1'b0) begin errors++;
         $display("FAIL mid_reset_grant r0=%b r1=%b en=%b expected 0 0 0", r0_ready, r1_ready, ps_alu_en); end
      tick(); tick();
      reset = 1'b1; #1;
      checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++;
         $display("FAIL mid_first_tie r0=%b r1=%b expected 1 0", r0_ready, r1_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++;
         $display("FAIL mid_dropped rsp_valid=%b expected 0", rsp_valid); end
      tick(); r0_valid = 1'b0; r1_valid = 1'b0;
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_saturate();
      test_round_robin();
      test_back_to_back();
      test_stall();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
